// File: rtl/shift_pkg.sv
// Shared types and funct decode for the multicycle shifter.
`timescale 1ns/1ps
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shift_kind_t;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  typedef struct packed {
    logic        legal;
    shift_kind_t kind;
  } decode_t;

  function automatic decode_t decode_funct(input logic [5:0] funct);
    decode_t d;
    d.legal = 1'b1;
    d.kind  = SH_LL;
    case (funct)
      FUNCT_SLL, FUNCT_SLLV: d.kind = SH_LL;
      FUNCT_SRL:             d.kind = SH_RL;
      FUNCT_SRA, FUNCT_SRAV: d.kind = SH_RA;
      default:               d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data by step positions of the given kind.
`timescale 1ns/1ps
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [WIDTH-1:0]   i_data,
  input  shift_kind_t        i_kind,
  input  logic [SHAMT_W-1:0] i_step,
  output logic [WIDTH-1:0]   o_data
);

  always_comb begin
    o_data = i_data;
    case (i_kind)
      SH_LL:   o_data = i_data << i_step;
      SH_RL:   o_data = i_data >> i_step;
      // Arithmetic fill copies the register's current top bit on every step.
      SH_RA:   o_data = $signed(i_data) >>> i_step;
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/serial_shift_unit.sv
// Multicycle sll/srl/sra/sllv/srav shifter: FSM plus data and count registers.
`timescale 1ns/1ps
module serial_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int SHAMT_W        = $clog2(WIDTH),
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic [WIDTH-1:0]   result,
  output state_t             dbg_state
);

  // Handshake: start is taken only in IDLE (busy==0); operands need be valid
  // only in that cycle; done pulses once with illegal and result valid.
  localparam logic [SHAMT_W-1:0] BPC_W = SHAMT_W'(BITS_PER_CYCLE);

  state_t             r_state;
  shift_kind_t        r_kind;
  logic [WIDTH-1:0]   r_data;
  logic [SHAMT_W-1:0] r_count;
  logic               r_illegal;

  decode_t            w_dec;
  logic [SHAMT_W-1:0] w_step;
  logic [WIDTH-1:0]   w_shifted;

  assign w_dec  = decode_funct(funct);
  assign w_step = (r_count < BPC_W) ? r_count : BPC_W;

  shift_step #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_step (
    .i_data (r_data),
    .i_kind (r_kind),
    .i_step (w_step),
    .o_data (w_shifted)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_kind    <= SH_LL;
      r_data    <= '0;
      r_count   <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_data    <= data_in;
            r_count   <= shamt;
            r_kind    <= w_dec.kind;
            r_illegal <= ~w_dec.legal;
            r_state   <= (!w_dec.legal || shamt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          r_data  <= w_shifted;
          r_count <= r_count - w_step;
          if (r_count == w_step) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = (r_state == SHIFT) || (r_state == DONE);
  assign done      = (r_state == DONE);
  assign illegal   = r_illegal;
  assign result    = r_data;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed bench for serial_shift_unit at BITS_PER_CYCLE 1 and 4.
`timescale 1ns/1ps
module tb_serial_shift_unit;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [5:0]  funct = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] data_in = '0;

  logic        busy_a, done_a, ill_a;
  logic [31:0] res_a;
  state_t      st_a;
  logic        busy_b, done_b, ill_b;
  logic [31:0] res_b;
  state_t      st_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_shift_unit #(.WIDTH(32), .SHAMT_W(5), .BITS_PER_CYCLE(1)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .funct(funct), .shamt(shamt),
    .data_in(data_in), .busy(busy_a), .done(done_a), .illegal(ill_a),
    .result(res_a), .dbg_state(st_a)
  );

  serial_shift_unit #(.WIDTH(32), .SHAMT_W(5), .BITS_PER_CYCLE(4)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .funct(funct), .shamt(shamt),
    .data_in(data_in), .busy(busy_b), .done(done_b), .illegal(ill_b),
    .result(res_b), .dbg_state(st_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start one op in cycle 0, then watch cycles 1..exp_cyc+3 with operands scrambled.
  task automatic run_op(input string tag, input bit use4, input logic [5:0] f,
                        input logic [4:0] sa, input logic [31:0] d, input int exp_cyc,
                        input logic [31:0] exp_res, input logic exp_ill, input bit pulses);
    int ndone, nbusy, done_cyc;
    logic ill_at_done;
    logic [31:0] res_at_done;
    ndone = 0; nbusy = 0; done_cyc = -1; ill_at_done = 1'bx; res_at_done = 'x;
    @(posedge clk); #1;
    funct = f; shamt = sa; data_in = d;
    if (use4) start_b = 1'b1; else start_a = 1'b1;
    for (int cyc = 1; cyc <= exp_cyc + 3; cyc++) begin
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      funct   = 6'($urandom_range(0, 63));
      shamt   = 5'($urandom_range(0, 31));
      data_in = $urandom;
      if (pulses && cyc < exp_cyc && (cyc % 2 == 1)) begin
        if (use4) start_b = 1'b1; else start_a = 1'b1;
      end
      if (use4 ? busy_b : busy_a) nbusy++;
      if (use4 ? done_b : done_a) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc    = cyc;
          ill_at_done = use4 ? ill_b : ill_a;
          res_at_done = use4 ? res_b : res_a;
        end
      end
    end
    start_a = 1'b0; start_b = 1'b0;
    chk({tag, ".done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
    chk({tag, ".done_count"}, 32'(ndone), 32'd1);
    chk({tag, ".busy_cycles"}, 32'(nbusy), 32'(exp_cyc));
    chk({tag, ".result"}, res_at_done, exp_res);
    chk({tag, ".illegal"}, {31'd0, ill_at_done}, {31'd0, exp_ill});
    chk({tag, ".result_held"}, use4 ? res_b : res_a, exp_res);
    chk({tag, ".illegal_held"}, {31'd0, use4 ? ill_b : ill_a}, {31'd0, exp_ill});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset.busy", {31'd0, busy_a}, 32'd0);
    chk("reset.done", {31'd0, done_a}, 32'd0);
    chk("reset.illegal", {31'd0, ill_a}, 32'd0);
    chk("reset.result", res_a, 32'd0);
    chk("reset.state", 32'(st_a), 32'(IDLE));
    chk("reset.result_b", res_b, 32'd0);

    run_op("sll31",  1'b0, FUNCT_SLL,  5'd31, 32'h0000_0001, 32, 32'h8000_0000, 1'b0, 1'b0);
    run_op("sra4",   1'b0, FUNCT_SRA,  5'd4,  32'h8000_0000, 5,  32'hF800_0000, 1'b0, 1'b0);
    run_op("srl4",   1'b0, FUNCT_SRL,  5'd4,  32'h8000_0000, 5,  32'h0800_0000, 1'b0, 1'b0);
    run_op("srav0",  1'b0, FUNCT_SRAV, 5'd0,  32'h7FFF_FFF0, 1,  32'h7FFF_FFF0, 1'b0, 1'b0);
    run_op("illeg",  1'b0, 6'b000001,  5'd9,  32'h1234_5678, 1,  32'h1234_5678, 1'b1, 1'b0);
    run_op("sllv4",  1'b0, FUNCT_SLLV, 5'd4,  32'h0000_00FF, 5,  32'h0000_0FF0, 1'b0, 1'b0);
    run_op("srl8p",  1'b0, FUNCT_SRL,  5'd8,  32'hF000_0000, 9,  32'h00F0_0000, 1'b0, 1'b1);
    run_op("b4srl8", 1'b1, FUNCT_SRL,  5'd8,  32'hF000_0000, 3,  32'h00F0_0000, 1'b0, 1'b1);
    run_op("b4sra7", 1'b1, FUNCT_SRA,  5'd7,  32'h8000_0000, 3,  32'hFF00_0000, 1'b0, 1'b0);
    run_op("b4sll31",1'b1, FUNCT_SLL,  5'd31, 32'h0000_0003, 9,  32'h8000_0000, 1'b0, 1'b0);

    // Reset in cycle 3 of an sll by 10 discards the operation.
    @(posedge clk); #1;
    funct = FUNCT_SLL; shamt = 5'd10; data_in = 32'h0000_0001; start_a = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
    end
    chk("rst_mid.busy_before", {31'd0, busy_a}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid.busy", {31'd0, busy_a}, 32'd0);
    chk("rst_mid.done", {31'd0, done_a}, 32'd0);
    chk("rst_mid.result", res_a, 32'd0);
    chk("rst_mid.state", 32'(st_a), 32'(IDLE));
    run_op("post_rst", 1'b0, FUNCT_SRL, 5'd31, 32'h8000_0000, 32, 32'h0000_0001, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
